// File: rtl/angle_recorder_pkg.sv
// angle_recorder_pkg: shared angle limits, FSM encoding and word layout
// used by both the recorder and the sequence player.
package angle_recorder_pkg;

  localparam logic signed [7:0] ANGLE_MAX = 8'sd90;
  localparam logic signed [7:0] ANGLE_MIN = -8'sd90;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_STORE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int S1_LSB = 16;
  localparam int S2_LSB = 8;
  localparam int S3_LSB = 0;

  function automatic logic [23:0] pack_angles(
    input logic [7:0] a1,
    input logic [7:0] a2,
    input logic [7:0] a3
  );
    logic [23:0] w;
    w = '0;
    w[S1_LSB +: 8] = a1;
    w[S2_LSB +: 8] = a2;
    w[S3_LSB +: 8] = a3;
    return w;
  endfunction

endpackage

// File: rtl/angle_recorder_clamp.sv
// angle_clamp: limits one signed 8-bit angle
// to the servo range [ANGLE_MIN, ANGLE_MAX].
module angle_clamp
  import angle_recorder_pkg::*;
(
  input  logic [7:0] angle_i,
  output logic [7:0] angle_o
);

  // saturate outside the servo range, pass through otherwise
  always_comb begin
    angle_o = angle_i;
    if ($signed(angle_i) > ANGLE_MAX) begin
      angle_o = ANGLE_MAX;
    end else if ($signed(angle_i) < ANGLE_MIN) begin
      angle_o = ANGLE_MIN;
    end
  end

endmodule

// File: rtl/angle_recorder.sv
// angle_recorder: samples clamped servo angle triples every
// WAIT_TICKS cycles into a MEMORY_SIZE x 24 RAM.
module angle_recorder
  import angle_recorder_pkg::*;
#(
  parameter int TIME_MS       = 20,
  parameter int MEMORY_SIZE   = 128,
  parameter int CLOCK_FREQ_HZ = 50000000,
  localparam int AW = $clog2(MEMORY_SIZE)
) (
  input  logic          clk,
  input  logic          rst_a_n,
  input  logic          start_signal,
  input  logic          stop_signal,
  input  logic [7:0]    servo1_angle_in,
  input  logic [7:0]    servo2_angle_in,
  input  logic [7:0]    servo3_angle_in,
  input  logic [AW-1:0] rd_addr,
  output logic [23:0]   rd_data,
  output logic          recording,
  output logic          full,
  output logic [AW:0]   sample_count
);

  localparam int WAIT_TICKS = TIME_MS * (CLOCK_FREQ_HZ / 1000);
  localparam int CW = $clog2(WAIT_TICKS);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_TICKS - 2);
  localparam logic [AW-1:0] ADDR_LAST = AW'(MEMORY_SIZE - 1);

  logic [7:0] c1, c2, c3;

  angle_clamp u_clamp1 (.angle_i(servo1_angle_in), .angle_o(c1));
  angle_clamp u_clamp2 (.angle_i(servo2_angle_in), .angle_o(c2));
  angle_clamp u_clamp3 (.angle_i(servo3_angle_in), .angle_o(c3));

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          full_q, full_d;
  logic          we;

  logic [23:0]   mem_q [MEMORY_SIZE];
  logic [23:0]   rd_q;

  // next-state and datapath control
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    full_d  = full_q;
    we      = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_signal && !stop_signal) begin
          state_d = ST_STORE;
          addr_d  = '0;
          cnt_d   = '0;
          wait_d  = '0;
          full_d  = 1'b0;
        end
      end
      ST_STORE: begin
        we     = 1'b1;
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (addr_q == ADDR_LAST) begin
          full_d  = 1'b1;
          state_d = ST_DONE;
        end else if (stop_signal) begin
          state_d = ST_DONE;
        end else begin
          wait_d  = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wait_d = wait_q + 1'b1;
        if (stop_signal) begin
          state_d = ST_DONE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_STORE;
        end
      end
    endcase
  end

  // control state registers
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      full_q  <= full_d;
    end
  end

  // sample RAM write port, contents not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr_q] <= pack_angles(c1, c2, c3);
    end
  end

  // registered read port, returns old data on a same-cycle write
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem_q[rd_addr];
    end
  end

  assign rd_data      = rd_q;
  assign recording    = (state_q == ST_STORE) || (state_q == ST_WAIT);
  assign full         = full_q;
  assign sample_count = cnt_q;

endmodule

// File: tb/tb_angle_recorder.sv
// tb_angle_recorder: random and directed stimulus checked
// against a cycle-countdown reference model.
module tb_angle_recorder;

  localparam int MS = 4;
  localparam int WT = 10;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_a_n = 1'b0;
  logic          start_signal = 1'b0;
  logic          stop_signal = 1'b0;
  logic [7:0]    s1 = '0, s2 = '0, s3 = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [23:0]   rd_data;
  logic          recording;
  logic          full;
  logic [AW:0]   sample_count;

  always #5 clk = ~clk;

  angle_recorder #(
    .TIME_MS(1),
    .MEMORY_SIZE(MS),
    .CLOCK_FREQ_HZ(10000)
  ) dut (
    .clk(clk),
    .rst_a_n(rst_a_n),
    .start_signal(start_signal),
    .stop_signal(stop_signal),
    .servo1_angle_in(s1),
    .servo2_angle_in(s2),
    .servo3_angle_in(s3),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .recording(recording),
    .full(full),
    .sample_count(sample_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // model: recording flag plus cycles remaining until the next write
  bit          m_rec, m_full, m_rd_vld;
  int          m_count, m_due;
  logic [23:0] m_mem [MS];
  bit          m_vld [MS];
  logic [23:0] m_rd;

  function automatic int clampv(input int v);
    if (v > 90) return 90;
    if (v < -90) return -90;
    return v;
  endfunction

  function automatic logic [23:0] word(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [7:0] c);
    int ia, ib, ic;
    ia = $signed(a);
    ib = $signed(b);
    ic = $signed(c);
    return {8'(clampv(ia)), 8'(clampv(ib)), 8'(clampv(ic))};
  endfunction

  task automatic model_reset();
    m_rec = 0; m_full = 0; m_count = 0; m_due = 0;
    m_rd = '0; m_rd_vld = 1;
  endtask

  task automatic model_step();
    m_rd_vld = m_vld[rd_addr];
    m_rd = m_mem[rd_addr];
    if (!m_rec) begin
      if (start_signal && !stop_signal) begin
        m_rec = 1; m_count = 0; m_full = 0; m_due = 0;
      end
    end else if (m_due == 0) begin
      m_mem[m_count] = word(s1, s2, s3);
      m_vld[m_count] = 1;
      m_count++;
      if (m_count == MS) begin
        m_full = 1; m_rec = 0;
      end else if (stop_signal) begin
        m_rec = 0;
      end else begin
        m_due = WT - 1;
      end
    end else if (stop_signal) begin
      m_rec = 0;
    end else begin
      m_due--;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("recording", recording, m_rec);
    chk("full", full, m_full);
    chk("sample_count", sample_count, m_count);
    if (m_rd_vld) chk("rd_data", rd_data, m_rd);
  endtask

  task automatic rnd_in();
    s1 = 8'($urandom);
    s2 = 8'($urandom);
    s3 = 8'($urandom);
    rd_addr = AW'($urandom);
  endtask

  logic [23:0] saved;
  int guard;

  initial begin
    for (int i = 0; i < MS; i++) m_vld[i] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_data", rd_data, 24'h0);
    chk("rst_recording", recording, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_count", sample_count, 0);
    rst_a_n = 1'b1;

    // basic start, one sample, read back
    s1 = 8'd10; s2 = 8'(-20); s3 = 8'd30; rd_addr = '0;
    start_signal = 1'b1;
    cycle();
    start_signal = 1'b0;
    cycle();
    chk("t1_count", sample_count, 1);
    cycle();
    chk("t1_rd", rd_data, 24'h0AEC1E);
    stop_signal = 1'b1;
    cycle();
    stop_signal = 1'b0;

    // held start with changing inputs, then run to full
    start_signal = 1'b1;
    for (int i = 0; i < 25; i++) begin
      rnd_in();
      cycle();
    end
    start_signal = 1'b0;
    for (int i = 0; i < 30; i++) begin
      rnd_in();
      cycle();
    end
    chk("t4_full", full, 1'b1);
    chk("t4_count", sample_count, MS);
    chk("t4_rec", recording, 1'b0);

    // clamp extremes
    s1 = 8'd127; s2 = 8'h80; s3 = 8'd90; rd_addr = '0;
    start_signal = 1'b1;
    cycle();
    start_signal = 1'b0;
    cycle();
    cycle();
    chk("t3_clamp", rd_data, 24'h5AA65A);
    stop_signal = 1'b1;
    cycle();
    stop_signal = 1'b0;

    // stop in WAIT after two samples
    start_signal = 1'b1;
    cycle();
    start_signal = 1'b0;
    guard = 0;
    while (!(m_count == 2 && m_rec && m_due == 4) && guard < 100) begin
      rnd_in();
      cycle();
      guard++;
    end
    chk("t5_timeout", guard < 100, 1'b1);
    stop_signal = 1'b1;
    cycle();
    stop_signal = 1'b0;
    chk("t5_rec", recording, 1'b0);
    chk("t5_count", sample_count, 2);

    // stop coincident with the first STORE
    s1 = 8'd45; s2 = 8'(-45); s3 = 8'd0;
    start_signal = 1'b1;
    cycle();
    start_signal = 1'b0;
    stop_signal = 1'b1;
    rd_addr = '0;
    cycle();
    stop_signal = 1'b0;
    chk("t5s_rec", recording, 1'b0);
    chk("t5s_count", sample_count, 1);
    cycle();
    chk("t5s_rd", rd_data, 24'h2DD300);

    // start and stop together in DONE
    start_signal = 1'b1;
    stop_signal = 1'b1;
    repeat (3) cycle();
    chk("t5b_rec", recording, 1'b0);
    chk("t5b_count", sample_count, 1);
    start_signal = 1'b0;
    stop_signal = 1'b0;

    // reset in the middle of WAIT
    start_signal = 1'b1;
    cycle();
    start_signal = 1'b0;
    guard = 0;
    while (!(m_count == 1 && m_rec && m_due == 5) && guard < 100) begin
      rnd_in();
      cycle();
      guard++;
    end
    chk("t6_timeout", guard < 100, 1'b1);
    saved = m_mem[0];
    rst_a_n = 1'b0;
    #1;
    chk("t6_rec", recording, 1'b0);
    chk("t6_full", full, 1'b0);
    chk("t6_count", sample_count, 0);
    chk("t6_rd", rd_data, 24'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a_n = 1'b1;
    rd_addr = '0;
    cycle();
    chk("t6_keep", rd_data, saved);
    s1 = 8'd1; s2 = 8'd2; s3 = 8'd3;
    start_signal = 1'b1;
    cycle();
    start_signal = 1'b0;
    cycle();
    cycle();
    chk("t6_over", rd_data, 24'h010203);

    // random control traffic
    for (int i = 0; i < 400; i++) begin
      rnd_in();
      start_signal = ($urandom_range(0, 19) == 0);
      stop_signal = ($urandom_range(0, 29) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
